// File: rtl/fdc_xfer_engine.sv
// Multi-sector data-phase engine for the floppy controller: walks sectors R..EOT,
// buffers each sector in a local byte FIFO, and reports EOC/overrun/no-data/WP status.
module fdc_xfer_engine #(
    parameter int NUM_DRIVES = 2,
    parameter int MAX_N      = 2,
    parameter int FIFO_AW    = 9,
    parameter int OVR_CYCLES = 4096,
    localparam int DRV_W     = (NUM_DRIVES > 1) ? $clog2(NUM_DRIVES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  dir,
    input  logic [DRV_W-1:0]      drive,
    input  logic [6:0]            cyl,
    input  logic                  head,
    input  logic [7:0]            sect_r,
    input  logic [7:0]            sect_eot,
    input  logic [2:0]            n_code,
    input  logic [7:0]            dtl,
    input  logic                  tc,
    input  logic                  cpu_rd,
    input  logic                  cpu_wr,
    input  logic [7:0]            cpu_din,
    output logic [7:0]            cpu_dout,
    output logic                  rqm,
    output logic                  busy,
    output logic                  done,
    output logic                  st_eoc,
    output logic                  st_ovr,
    output logic                  st_nodata,
    output logic                  st_wp,
    output logic [7:0]            last_sect,
    output logic                  dk_rd_req,
    output logic                  dk_wr_req,
    output logic [DRV_W+15:0]     dk_addr,
    input  logic                  dk_ack,
    input  logic                  dk_err,
    input  logic [NUM_DRIVES-1:0] dk_wp,
    input  logic [7:0]            dk_din,
    input  logic                  dk_din_vld,
    output logic [7:0]            dk_dout,
    input  logic                  dk_dout_rd
);

    localparam int LEN_W = $clog2(128 << MAX_N) + 1;
    localparam int OVR_W = $clog2(OVR_CYCLES + 1);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CNT_W = FIFO_AW + 1;
    localparam logic [2:0] MAX_N_C = 3'(MAX_N);

    typedef enum logic [2:0] {
        IDLE, CHECK, REQ, RDXFER, WRFILL, WRCOMMIT, NEXT, FINISH
    } state_t;

    state_t state, state_next;

    logic             dir_q;
    logic [DRV_W-1:0] drive_q;
    logic [6:0]       cyl_q;
    logic             head_q;
    logic [7:0]       sect_q;
    logic [7:0]       eot_q;
    logic [2:0]       n_q;
    logic [7:0]       dtl_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] xfer_cnt;
    logic [LEN_W-1:0] rx_cnt;
    logic [OVR_W-1:0] ovr_cnt;
    logic             tc_seen;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [CNT_W-1:0]   fifo_cnt;

    logic fifo_empty, fifo_full;
    logic bad_n, wp_hit;
    logic disk_push, cpu_push, push, cpu_pop, disk_pop, pop;
    logic [7:0] push_data;
    logic strobe, ovr_run, ovr_hit, xfer_last, tc_any;
    logic enter_sector, flush;
    logic [7:0] sect_inc;

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == CNT_W'(DEPTH));
    assign bad_n      = (n_q > MAX_N_C) || (n_q == 3'd0 && dtl_q == 8'd0);
    assign wp_hit     = dir_q && dk_wp[drive_q];

    // Disk bytes past the sector length are dropped, so the CPU never sees them.
    assign disk_push = (state == REQ || state == RDXFER) && dk_din_vld
                       && (rx_cnt < len_q) && !fifo_full;
    assign cpu_push  = (state == WRFILL) && cpu_wr && !fifo_full;
    assign push      = disk_push || cpu_push;
    assign push_data = (state == WRFILL) ? cpu_din : dk_din;
    assign cpu_pop   = (state == RDXFER) && cpu_rd && !fifo_empty;
    assign disk_pop  = (state == WRCOMMIT) && dk_dout_rd && !fifo_empty;
    assign pop       = cpu_pop || disk_pop;

    assign rqm       = ((state == RDXFER) && !fifo_empty) || (state == WRFILL);
    assign strobe    = ((state == RDXFER) && cpu_rd) || ((state == WRFILL) && cpu_wr);
    assign ovr_run   = rqm && !strobe;
    assign ovr_hit   = ovr_run && (ovr_cnt == OVR_W'(OVR_CYCLES - 1));
    assign xfer_last = (xfer_cnt == len_q - LEN_W'(1));
    assign tc_any    = tc_seen || tc;
    assign sect_inc  = sect_q + 8'd1;

    assign busy      = (state != IDLE);
    assign done      = (state == FINISH);
    assign dk_rd_req = (state == REQ);
    assign dk_wr_req = (state == WRCOMMIT);
    assign dk_addr   = {drive_q, head_q, cyl_q, sect_q};
    assign dk_dout   = (state == WRCOMMIT) ? mem[rd_ptr] : 8'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (start) state_next = CHECK;
            CHECK:    if (bad_n || wp_hit) state_next = FINISH;
                      else state_next = dir_q ? WRFILL : REQ;
            REQ:      if (dk_ack) state_next = dk_err ? FINISH : RDXFER;
            RDXFER:   if (cpu_pop && xfer_last) state_next = NEXT;
                      else if (ovr_hit) state_next = FINISH;
            WRFILL:   if (cpu_push && xfer_last) state_next = WRCOMMIT;
                      else if (ovr_hit) state_next = FINISH;
            WRCOMMIT: if (dk_ack) state_next = dk_err ? FINISH : NEXT;
            NEXT:     if (tc_any || sect_q == eot_q) state_next = FINISH;
                      else state_next = dir_q ? WRFILL : REQ;
            FINISH:   state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    assign enter_sector = (state == CHECK || state == NEXT)
                          && (state_next == REQ || state_next == WRFILL);
    assign flush = enter_sector
                   || ((state == RDXFER || state == WRFILL) && state_next == FINISH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_q     <= 1'b0;
            drive_q   <= '0;
            cyl_q     <= '0;
            head_q    <= 1'b0;
            sect_q    <= '0;
            eot_q     <= '0;
            n_q       <= '0;
            dtl_q     <= '0;
            len_q     <= '0;
            xfer_cnt  <= '0;
            rx_cnt    <= '0;
            ovr_cnt   <= '0;
            tc_seen   <= 1'b0;
            st_eoc    <= 1'b0;
            st_ovr    <= 1'b0;
            st_nodata <= 1'b0;
            st_wp     <= 1'b0;
            last_sect <= '0;
            cpu_dout  <= '0;
        end else begin
            if (state == IDLE && start) begin
                dir_q     <= dir;
                drive_q   <= drive;
                cyl_q     <= cyl;
                head_q    <= head;
                sect_q    <= sect_r;
                eot_q     <= sect_eot;
                n_q       <= n_code;
                dtl_q     <= dtl;
                tc_seen   <= 1'b0;
                st_eoc    <= 1'b0;
                st_ovr    <= 1'b0;
                st_nodata <= 1'b0;
                st_wp     <= 1'b0;
                last_sect <= '0;
            end else if (state != IDLE && tc) begin
                tc_seen <= 1'b1;
            end

            if (state == CHECK) begin
                len_q     <= (n_q == 3'd0) ? LEN_W'(dtl_q) : (LEN_W'(128) << n_q);
                st_nodata <= bad_n;
                st_wp     <= !bad_n && wp_hit;
            end

            if (cpu_pop) cpu_dout <= mem[rd_ptr];
            if (disk_push) rx_cnt <= rx_cnt + LEN_W'(1);
            if (cpu_pop || cpu_push) xfer_cnt <= xfer_cnt + LEN_W'(1);
            ovr_cnt <= ovr_run ? ovr_cnt + OVR_W'(1) : '0;

            if (enter_sector) begin
                xfer_cnt <= '0;
                rx_cnt   <= '0;
                if (state == NEXT) sect_q <= sect_inc;
            end

            if (state_next == REQ && state != REQ)
                last_sect <= (state == NEXT) ? sect_inc : sect_q;
            if (state_next == WRCOMMIT && state != WRCOMMIT)
                last_sect <= sect_q;

            if (ovr_hit) st_ovr <= 1'b1;
            if ((state == REQ || state == WRCOMMIT) && dk_ack && dk_err) st_nodata <= 1'b1;
            // A terminal count ends the run cleanly without claiming end-of-cylinder.
            if (state == NEXT && !tc_any && sect_q == eot_q) st_eoc <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fdc_xfer_engine.sv
// Table-driven bench for fdc_xfer_engine: a behavioural disk image model plus a CPU
// loop per vector, followed by a hand-written mid-transfer reset sequence.
module tb_fdc_xfer_engine;

    localparam int OVR = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, dir = 1'b0;
    logic [0:0]  drive = '0;
    logic [6:0]  cyl = '0;
    logic        head = 1'b0;
    logic [7:0]  sect_r = '0, sect_eot = '0, dtl = '0;
    logic [2:0]  n_code = '0;
    logic        tc = 1'b0, cpu_rd = 1'b0, cpu_wr = 1'b0;
    logic [7:0]  cpu_din = '0, cpu_dout;
    logic        rqm, busy, done, st_eoc, st_ovr, st_nodata, st_wp;
    logic [7:0]  last_sect;
    logic        dk_rd_req, dk_wr_req;
    logic [16:0] dk_addr;
    logic        dk_ack = 1'b0, dk_err = 1'b0;
    logic [1:0]  dk_wp = '0;
    logic [7:0]  dk_din = '0, dk_dout;
    logic        dk_din_vld = 1'b0, dk_dout_rd = 1'b0;

    fdc_xfer_engine #(.NUM_DRIVES(2), .MAX_N(2), .FIFO_AW(9), .OVR_CYCLES(OVR)) dut (
        .clk(clk), .rst(rst), .start(start), .dir(dir), .drive(drive), .cyl(cyl),
        .head(head), .sect_r(sect_r), .sect_eot(sect_eot), .n_code(n_code), .dtl(dtl),
        .tc(tc), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
        .rqm(rqm), .busy(busy), .done(done), .st_eoc(st_eoc), .st_ovr(st_ovr),
        .st_nodata(st_nodata), .st_wp(st_wp), .last_sect(last_sect),
        .dk_rd_req(dk_rd_req), .dk_wr_req(dk_wr_req), .dk_addr(dk_addr),
        .dk_ack(dk_ack), .dk_err(dk_err), .dk_wp(dk_wp), .dk_din(dk_din),
        .dk_din_vld(dk_din_vld), .dk_dout(dk_dout), .dk_dout_rd(dk_dout_rd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string    name;
        bit       dir;
        bit       drv;
        bit [6:0] cyl;
        bit       hd;
        bit [7:0] r, eot;
        bit [2:0] n;
        bit [7:0] dtl;
        bit [1:0] wp;
        int       extra;
        bit       err;
        int       tc_sect;
        int       cpu_limit;
        bit       e_eoc, e_ovr, e_nod, e_wp;
        int       e_last;
        int       e_rd, e_wr, e_bytes;
        int       lat_mode;
        int       e_lat;
    } vec_t;

    vec_t tbl [10];

    int checks = 0, failures = 0;

    int       cfg_len, cfg_extra, cfg_tc_sect;
    bit       cfg_err, cfg_drv, cfg_hd;
    bit [6:0] cfg_cyl;
    bit [7:0] cfg_r;
    int       rd_reqs, wr_reqs, wr_idx, addr_errs, data_errs;

    function automatic bit [7:0] rpat(input bit [7:0] s, input int i);
        return 8'(int'(s) * 3 + i + (i >> 8) * 17);
    endfunction

    function automatic bit [7:0] wpat(input int k);
        return 8'(k * 5 + (k >> 8) + 33);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic setCfg(input vec_t v);
        cfg_len     = (v.n == 0) ? int'(v.dtl) : (128 << v.n);
        cfg_extra   = v.extra;
        cfg_tc_sect = v.tc_sect;
        cfg_err     = v.err;
        cfg_drv     = v.drv;
        cfg_hd      = v.hd;
        cfg_cyl     = v.cyl;
        cfg_r       = v.r;
        rd_reqs = 0; wr_reqs = 0; wr_idx = 0; addr_errs = 0; data_errs = 0;
    endtask

    // Disk image model: serves read/write requests, checks addresses and write data.
    initial begin
        bit [7:0]  cur;
        bit [16:0] exp_addr;
        forever begin
            @(negedge clk);
            if (!rst && dk_rd_req) begin
                cur = dk_addr[7:0];
                exp_addr = {cfg_drv, cfg_hd, cfg_cyl, 8'(cfg_r + 8'(rd_reqs))};
                if (dk_addr !== exp_addr) addr_errs++;
                rd_reqs++;
                if (cfg_tc_sect >= 0 && int'(cur) == cfg_tc_sect) tc = 1'b1;
                for (int i = 0; i < cfg_len + cfg_extra; i++) begin
                    dk_din = rpat(cur, i);
                    dk_din_vld = 1'b1;
                    @(negedge clk);
                    tc = 1'b0;
                end
                dk_din_vld = 1'b0;
                dk_ack = 1'b1; dk_err = cfg_err;
                @(negedge clk);
                dk_ack = 1'b0; dk_err = 1'b0;
            end else if (!rst && dk_wr_req) begin
                exp_addr = {cfg_drv, cfg_hd, cfg_cyl, 8'(cfg_r + 8'(wr_reqs))};
                if (dk_addr !== exp_addr) addr_errs++;
                wr_reqs++;
                for (int i = 0; i < cfg_len; i++) begin
                    if (dk_dout !== wpat(wr_idx)) data_errs++;
                    wr_idx++;
                    dk_dout_rd = 1'b1;
                    @(negedge clk);
                end
                dk_dout_rd = 1'b0;
                dk_ack = 1'b1; dk_err = cfg_err;
                @(negedge clk);
                dk_ack = 1'b0; dk_err = 1'b0;
            end
        end
    end

    task automatic startXfer(input vec_t v, output int t0);
        @(negedge clk);
        dir = v.dir; drive = v.drv; cyl = v.cyl; head = v.hd;
        sect_r = v.r; sect_eot = v.eot; n_code = v.n; dtl = v.dtl; dk_wp = v.wp;
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        int  t0, t_done, t_strobe, k, j;
        bit  got_done, prev, rd_pending;
        bit [7:0] s;
        bit  s_eoc, s_ovr, s_nod, s_wp;
        bit [7:0] s_last;
        setCfg(v);
        startXfer(v, t0);
        got_done = 0; prev = 0; rd_pending = 0; k = 0; t_done = 0; t_strobe = t0;
        s_eoc = 0; s_ovr = 0; s_nod = 0; s_wp = 0; s_last = 0;
        for (int b = 0; b < 20000 && !got_done; b++) begin
            if (rd_pending) begin
                j = k - 1;
                s = 8'(int'(v.r) + j / cfg_len);
                if (cpu_dout !== rpat(s, j % cfg_len)) data_errs++;
                rd_pending = 0;
            end
            cpu_rd = 1'b0; cpu_wr = 1'b0;
            if (done) begin
                got_done = 1; t_done = cyc;
                s_eoc = st_eoc; s_ovr = st_ovr; s_nod = st_nodata; s_wp = st_wp;
                s_last = last_sect;
            end else if (rqm && !prev && (v.cpu_limit < 0 || k < v.cpu_limit)) begin
                if (v.dir) begin cpu_wr = 1'b1; cpu_din = wpat(k); end
                else begin cpu_rd = 1'b1; rd_pending = 1; end
                t_strobe = cyc;
                k++; prev = 1;
            end else begin
                prev = 0;
            end
            if (!got_done) @(negedge clk);
        end
        checkOutput({v.name, ".done"}, 64'(got_done), 64'd1);
        checkOutput({v.name, ".st_eoc"}, 64'(s_eoc), 64'(v.e_eoc));
        checkOutput({v.name, ".st_ovr"}, 64'(s_ovr), 64'(v.e_ovr));
        checkOutput({v.name, ".st_nodata"}, 64'(s_nod), 64'(v.e_nod));
        checkOutput({v.name, ".st_wp"}, 64'(s_wp), 64'(v.e_wp));
        if (v.e_last >= 0) checkOutput({v.name, ".last_sect"}, 64'(s_last), 64'(v.e_last));
        checkOutput({v.name, ".rd_reqs"}, 64'(rd_reqs), 64'(v.e_rd));
        checkOutput({v.name, ".wr_reqs"}, 64'(wr_reqs), 64'(v.e_wr));
        checkOutput({v.name, ".cpu_bytes"}, 64'(k), 64'(v.e_bytes));
        checkOutput({v.name, ".data_errs"}, 64'(data_errs), 64'd0);
        checkOutput({v.name, ".addr_errs"}, 64'(addr_errs), 64'd0);
        if (v.lat_mode == 1) checkOutput({v.name, ".lat_start"}, 64'(t_done - t0), 64'(v.e_lat));
        if (v.lat_mode == 2) checkOutput({v.name, ".lat_strobe"}, 64'(t_done - t_strobe), 64'(v.e_lat));
        @(negedge clk);
        checkOutput({v.name, ".idle_after"}, {62'd0, busy, rqm}, 64'd0);
        repeat (3) @(negedge clk);
    endtask

    function automatic logic [63:0] allOuts();
        return 64'({cpu_dout, rqm, busy, done, st_eoc, st_ovr, st_nodata, st_wp, last_sect,
                    dk_rd_req, dk_wr_req, dk_addr, dk_dout});
    endfunction

    initial begin
        int t0, pops, done_cnt;
        //          name        dir drv cyl  hd r      eot    n  dtl    wp     ext er tc lim eoc ovr nod wp last rd wr bytes lm lat
        tbl[0] = '{"rd_2sect",  0, 0, 7'd3,  0, 8'hC1, 8'hC2, 2, 8'h00, 2'b00, 0, 0, -1, -1, 1, 0, 0, 0, 194, 2, 0, 1024, 0, 0};
        tbl[1] = '{"rd_dtl64",  0, 0, 7'd10, 1, 8'h05, 8'h05, 0, 8'h40, 2'b00, 16, 0, -1, -1, 1, 0, 0, 0, 5,  1, 0, 64,  0, 0};
        tbl[2] = '{"rd_tc",     0, 0, 7'd20, 1, 8'h01, 8'h09, 2, 8'h00, 2'b00, 0, 0, 2, -1,  0, 0, 0, 0, 2,   2, 0, 1024, 0, 0};
        tbl[3] = '{"wr_wp",     1, 1, 7'd5,  0, 8'h01, 8'h03, 2, 8'h00, 2'b10, 0, 0, -1, -1, 0, 0, 0, 1, -1,  0, 0, 0,   1, 2};
        tbl[4] = '{"wr_n1",     1, 0, 7'h55, 1, 8'h07, 8'h07, 1, 8'h00, 2'b10, 0, 0, -1, -1, 1, 0, 0, 0, 7,   0, 1, 256, 0, 0};
        tbl[5] = '{"rd_ovr",    0, 0, 7'd1,  0, 8'h03, 8'h03, 2, 8'h00, 2'b00, 0, 0, -1, 1,  0, 1, 0, 0, 3,   1, 0, 1,   2, OVR + 1};
        tbl[6] = '{"rd_err",    0, 1, 7'd2,  0, 8'h04, 8'h04, 1, 8'h00, 2'b00, 0, 1, -1, -1, 0, 0, 1, 0, 4,   1, 0, 0,   0, 0};
        tbl[7] = '{"bad_n5",    0, 0, 7'd0,  0, 8'h01, 8'h01, 5, 8'h00, 2'b00, 0, 0, -1, -1, 0, 0, 1, 0, -1,  0, 0, 0,   1, 2};
        tbl[8] = '{"wr_wrap",   1, 1, 7'd9,  0, 8'hFF, 8'h00, 0, 8'h04, 2'b00, 0, 0, -1, -1, 1, 0, 0, 0, 0,   0, 2, 8,   0, 0};
        tbl[9] = '{"bad_dtl0",  0, 0, 7'd0,  0, 8'h01, 8'h01, 0, 8'h00, 2'b00, 0, 0, -1, -1, 0, 0, 1, 0, -1,  0, 0, 0,   1, 2};

        repeat (3) @(negedge clk);
        checkOutput("reset_outs", allOuts(), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        foreach (tbl[i]) applyStimulus(tbl[i]);

        // Reset in the middle of a read data phase must kill everything without a done pulse.
        setCfg(tbl[5]);
        startXfer(tbl[5], t0);
        pops = 0;
        for (int b = 0; b < 3000 && pops < 10; b++) begin
            @(negedge clk);
            cpu_rd = 1'b0;
            if (rqm && b % 2 == 0) begin cpu_rd = 1'b1; pops++; end
        end
        @(negedge clk);
        cpu_rd = 1'b0;
        checkOutput("mid_pops", 64'(pops), 64'd10);
        checkOutput("mid_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        checkOutput("mid_reset_outs", allOuts(), 64'd0);
        done_cnt = 0;
        repeat (3) begin @(negedge clk); if (done) done_cnt++; end
        rst = 1'b0;
        repeat (4) begin @(negedge clk); if (done) done_cnt++; end
        checkOutput("mid_reset_no_done", 64'(done_cnt), 64'd0);

        applyStimulus(tbl[1]);
        applyStimulus(tbl[4]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fdc_xfer_engine.md
Name: fdc_xfer_engine

Overview:
- Parametrised multi-sector data-phase engine for the floppy controller.
- Replaces the single fixed 512-byte sector transfer with:
  - runs from R to EOT,
  - variable sector size (N/DTL),
  - N drives,
  - terminal-count abort,
  - overrun and write-protect detection.
- Sits between the command/result sequencer (which decodes commands and builds ST0–ST2) and the SD-card disk-image controller.
- Contains its own byte FIFO.

Parameters:
- NUM_DRIVES, 2: number of drive units; DRV_W = max(1, $clog2(NUM_DRIVES)).
- MAX_N, 2: largest supported N code; max sector = 128<<MAX_N bytes.
- FIFO_AW, 9: FIFO address width; requires 2**FIFO_AW >= 128<<MAX_N.
- OVR_CYCLES, 4096: clk cycles a pending CPU byte may wait before overrun.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse, begins transfer
- dir  in  1  0 = read, 1 = write
- drive  in  DRV_W  unit select
- cyl  in  7  cylinder
- head  in  1  head
- sect_r  in  8  first sector ID
- sect_eot  in  8  final sector ID
- n_code  in  3  sector size code
- dtl  in  8  byte count when n_code==0
- tc  in  1  terminal count pulse
- cpu_rd  in  1  CPU data-register read strobe (1 cycle)
- cpu_wr  in  1  CPU data-register write strobe (1 cycle)
- cpu_din  in  8  CPU write data
- cpu_dout  out  8  CPU read data
- rqm  out  1  byte pending for CPU
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- st_eoc  out  1  end of cylinder reached
- st_ovr  out  1  overrun
- st_nodata  out  1  sector not found / disk error / bad N
- st_wp  out  1  write protected
- last_sect  out  8  sector ID of last attempted sector
- dk_rd_req  out  1  disk read request (level)
- dk_wr_req  out  1  disk write request (level)
- dk_addr  out  DRV_W+16  {drive, head, cyl, sector}
- dk_ack  in  1  request complete (level)
- dk_err  in  1  valid with dk_ack
- dk_wp  in  NUM_DRIVES  per-drive write protect
- dk_din  in  8  read byte
- dk_din_vld  in  1  read byte strobe
- dk_dout  out  8  write byte = FIFO head
- dk_dout_rd  in  1  disk pops write byte

Behaviour:
- **Reset (async, rst=1):**
  - All outputs 0; state IDLE.
  - FIFO and counters cleared.
  - Takes effect mid-transfer too: requests drop immediately and no done pulse is issued.
- **Sector length:** L = (n_code==0) ? dtl : 128<<n_code, held in a $clog2(128<<MAX_N)+1-bit counter.
- **States:** IDLE, CHECK, REQ, RDXFER, WRFILL, WRCOMMIT, NEXT, FINISH.
- **IDLE:**
  - start latches all inputs; busy<=1; status bits cleared; goto CHECK.
  - start while busy is ignored.
- **CHECK:**
  - If n_code>MAX_N, or n_code==0 with dtl==0: st_nodata, goto FINISH.
  - Else if dir=1 and dk_wp[drive]: st_wp, goto FINISH.
  - Else read → REQ; write → WRFILL.
- **REQ (read):**
  - dk_rd_req=1 with dk_addr; FIFO flushed on entry.
  - Incoming dk_din_vld bytes are pushed to the FIFO as they arrive.
  - On dk_ack: drop request. dk_err → st_nodata, goto FINISH; else goto RDXFER.
- **RDXFER:**
  - rqm = FIFO not empty.
  - cpu_rd pops; cpu_dout is registered and updated on the cycle of cpu_rd.
  - A push and a pop in the same cycle are both honoured.
  - After L pops → NEXT. Bytes beyond L delivered by the disk are discarded.
- **WRFILL:**
  - rqm = 1 until L bytes have been received; cpu_wr pushes.
  - After L pushes → WRCOMMIT.
- **WRCOMMIT:**
  - dk_wr_req=1 with dk_addr; disk pops via dk_dout_rd.
  - On dk_ack: dk_err → st_nodata, goto FINISH; else goto NEXT.
- **NEXT:**
  - If tc was seen during this sector → FINISH, st_eoc=0.
  - Else if sector==sect_eot → st_eoc=1, FINISH.
  - Else sector+1 (8-bit, wraps FF→00); read → REQ, write → WRFILL.
- **tc handling:** tc is latched at any time while busy. If latched while in REQ/WRCOMMIT, it acts at NEXT.
- **Overrun:**
  - Counter runs while in RDXFER/WRFILL with rqm=1 and no CPU strobe; it resets on each strobe.
  - Reaching OVR_CYCLES → st_ovr, FIFO flushed, goto FINISH.
- **FINISH:**
  - done=1 for one cycle; busy<=0; rqm<=0; → IDLE.
  - Status bits and last_sect hold until the next start.
- **last_sect:** the current sector ID, updated on each REQ/WRCOMMIT entry.

Test Plan:
1. Read, drive 0, C=3 H=0 R=C1 EOT=C2 N=2: disk supplies 512 bytes per sector, CPU reads 1024 → two dk_rd_req with sectors C1 and C2, done, st_eoc=1, last_sect=C2, data identical.
2. Read, N=0 DTL=0x40, R=EOT=5: one request; rqm drops after 64 pops; extra disk bytes discarded; done, st_eoc=1.
3. Read R=1 EOT=9 N=2, tc pulsed during sector 2 → sector 2 completes, no sector 3 request, st_eoc=0, last_sect=2.
4. Write, dk_wp=2'b10, drive=1 → done within 3 cycles of start, st_wp=1, no dk_wr_req. Write on drive 0, N=1 → 256 CPU bytes, then dk_wr_req; dk_dout bytes match.
5. Read with CPU idle OVR_CYCLES after the first byte → st_ovr=1, done. dk_ack with dk_err=1 → st_nodata=1, done. n_code=5 → st_nodata.
6. Assert rst mid-RDXFER → all outputs 0 immediately, no done pulse; a subsequent start runs normally.
